adder_pipe_arbiter: RTL and testbench
=====================================

Name: adder_pipe_arbiter

Overview:
Shares one pipelined look-ahead adder chain (load/load_out valid-tagged, fixed latency) between N_REQ requesters. Round-robin arbitration, a registered issue stage, and a tag shift register aligned with the adder pipeline route each sum and carry back to its originating requester. A DRAIN state stops new issues and reports when the pipeline is empty, for reconfiguration or clean shutdown.

Parameters:
DATA_W, 8, operand/sum width driven to the adder chain
N_REQ, 2, number of requesters (2..8)
LATENCY, 2, adder cycles from load to load_out (one per stage)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester operation valid
req_ready  out  N_REQ  per-requester accept; transfer when valid&ready
req_op1  in  N_REQ*DATA_W  packed operand 1, slice i = requester i
req_op2  in  N_REQ*DATA_W  packed operand 2
req_cin  in  N_REQ  carry-in per requester
add_input_1  out  DATA_W  to adder input_1
add_input_2  out  DATA_W  to adder input_2
add_carry_in  out  1  to adder carry_in
add_load  out  1  to adder load
add_sum  in  DATA_W  from adder final sum
add_carry  in  1  from adder final carry
add_load_out  in  1  from adder final load_out
resp_valid  out  N_REQ  one-hot, 1-cycle result pulse
resp_sum  out  DATA_W  result sum (shared bus)
resp_carry  out  1  result carry
drain_req  in  1  level: request drain
drain_done  out  1  high while in DRAIN with zero in-flight ops
tag_err  out  1  sticky: add_load_out disagrees with tag pipe valid

Behaviour:
- Reset: all outputs 0, state RUN, rr pointer 0, tag pipe empty, in-flight count 0, tag_err 0. Reset mid-operation discards in-flight ops; no resp_valid issued for them.
- States: RUN (grant allowed); DRAIN (no grants). RUN->DRAIN when drain_req=1; DRAIN->RUN when drain_req=0 (in-flight ops still complete and respond normally).
- req_ready: combinational, one-hot or zero; in RUN grants the first valid requester at or after rr pointer (wrapping); all 0 in DRAIN. No valid -> all 0.
- On accept of requester g at cycle t: rr pointer <= (g+1) mod N_REQ; at t+1 add_load=1 with registered operands/cin. Otherwise add_load=0, operand regs hold.
- Tag pipe: LATENCY entries {valid, id}, shifts every cycle; entry 0 loaded with {add_load, id} of the issue stage. Tail aligns with add_load_out.
- At add_load_out=1: resp_valid[tail id] <= 1, resp_sum/resp_carry <= add_sum/add_carry (registered); result at t+2+LATENCY. resp_sum/carry hold last value otherwise.
- tag_err set when add_load_out != tail valid; cleared only by reset. On mismatch with add_load_out=1 and tail invalid: no resp_valid.
- In-flight count: +1 on accept, -1 on resp_valid, both same cycle -> unchanged; max 1+LATENCY+1. drain_done = (state==DRAIN)&&(count==0).
- Throughput: one op per cycle sustained; no result backpressure (requesters always sink resp).

Optional Feature:
ADDER_ARB_STATS_EN: when defined, adds output grant_cnt (N_REQ*16), per-requester saturating 16-bit accepted-op counters, reset to 0, held at 16'hFFFF. When undefined, port and counters absent; all other behaviour identical.

Decomposition:
- Package adder_arb_pkg: ID_W = $clog2(N_REQ) function, tag_t struct {logic valid; logic [ID_W-1:0] id;}, state enum {RUN, DRAIN}.
- One sub-module: rr_arbiter (N_REQ, req vector + pointer -> one-hot grant + grant index), combinational.

Test Plan:
- Single op: req0 op1=1, op2=2, cin=0 -> add_load at t+1 with 1/2; resp_valid=2'b01, resp_sum=3 at t+4 (LATENCY=2).
- Contention: both valid continuously, req0 3+4, req1 5+6 -> grants alternate 0,1,0,1; resp_valid alternates 01,10 with sums 7,11.
- Carry: req1 op1=8'hFF, op2=8'h01, cin=1 -> resp_sum=8'h01, resp_carry=1, resp_valid=2'b10.
- Drain: 3 ops in flight, assert drain_req -> req_ready=0 immediately; drain_done=1 the cycle after third resp_valid; drop drain_req -> grants resume.
- Reset mid-flight: reset with 2 ops in pipe -> no resp_valid afterwards, count 0, tag_err 0.
- Tag error: force add_load_out=1 with empty tag pipe -> tag_err=1 sticky, no resp_valid.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types for the pipelined-adder arbiter.
// Holds the requester-id width helper, the tag carried alongside each
// operation through the adder pipeline, and the RUN/DRAIN state encoding.
package adder_arb_pkg;

  // Widest requester id the tag can carry (N_REQ is limited to 8).
  localparam int MAX_ID_W = 3;

  // Number of bits needed to name one of n requesters (never less than 1).
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One tag-pipe entry: whether the matching adder stage holds a live
  // operation, and which requester it belongs to.
  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

  // RUN issues new operations; DRAIN only lets in-flight ones finish.
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/adder_pipe_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
// Grants the first asserted request at or after 'ptr', wrapping around.
// Outputs a one-hot grant, its index, and whether anything was granted.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx,
  output logic             grant_valid
);

  logic [ID_W-1:0] idx;

  // Walk the requesters starting at ptr; the first one found wins.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(ptr) + k) % N_REQ);
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/adder_pipe_arbiter.sv
// adder_pipe_arbiter: shares one external pipelined adder between N_REQ
// requesters. A round-robin arbiter feeds a registered issue stage that
// drives the adder; a tag shift register running in lock-step with the
// adder pipeline remembers who issued each operation so the result can be
// returned to that requester. DRAIN stops new issues and reports when the
// pipeline has emptied.
// Optional build macro ADDER_ARB_STATS_EN adds the grant_cnt output with
// per-requester saturating 16-bit accepted-operation counters.
module adder_pipe_arbiter
  import adder_arb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int N_REQ   = 2,
  parameter int LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_op1,
  input  logic [N_REQ*DATA_W-1:0] req_op2,
  input  logic [N_REQ-1:0]        req_cin,
  output logic [DATA_W-1:0]       add_input_1,
  output logic [DATA_W-1:0]       add_input_2,
  output logic                    add_carry_in,
  output logic                    add_load,
  input  logic [DATA_W-1:0]       add_sum,
  input  logic                    add_carry,
  input  logic                    add_load_out,
  output logic [N_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]       resp_sum,
  output logic                    resp_carry,
  input  logic                    drain_req,
  output logic                    drain_done,
  output logic                    tag_err,
`ifdef ADDER_ARB_STATS_EN
  output logic [N_REQ*16-1:0]     grant_cnt,
`endif
  output state_t                  dbg_state
);

  // Handshake: requester i transfers an operation on a rising clk edge where
  // req_valid[i] && req_ready[i]. A requester keeps req_valid and its
  // operands stable until that edge. req_ready is combinational, at most one
  // bit is set, and it never depends on req_ready itself. Results have no
  // backpressure: resp_valid is a single-cycle pulse the requester must take.

  localparam int ID_W  = id_w(N_REQ);
  // Holds 0 .. 1+LATENCY+1 outstanding operations with headroom.
  localparam int CNT_W = $clog2(LATENCY + 3) + 1;

  state_t            state;
  state_t            state_next;

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   next_ptr;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_valid;
  logic              grant_en;
  logic              accept;

  logic [DATA_W-1:0] sel_op1;
  logic [DATA_W-1:0] sel_op2;
  logic              sel_cin;

  logic              iss_valid;
  logic [ID_W-1:0]   iss_id;
  logic [DATA_W-1:0] op1_q;
  logic [DATA_W-1:0] op2_q;
  logic              cin_q;

  tag_t              tag_q [LATENCY];
  tag_t              tail;
  logic [N_REQ-1:0]  resp_onehot;

  logic [CNT_W-1:0]  inflight;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_arbiter (
    .req         (req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // State register for the RUN/DRAIN controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state follows the drain_req level; in-flight work is unaffected.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:   if (drain_req)  state_next = ST_DRAIN;
      ST_DRAIN: if (!drain_req) state_next = ST_RUN;
      default:  state_next = ST_RUN;
    endcase
  end

  // Grants are blocked in DRAIN and also the moment drain_req rises, so a
  // drain request never lets one more operation slip in.
  always_comb begin
    grant_en  = (state == ST_RUN) && !drain_req;
    req_ready = grant_en ? grant : '0;
    accept    = grant_en && grant_valid;
    next_ptr  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  // Select the granted requester's operands (grant is one-hot).
  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_op1 = req_op1[i*DATA_W +: DATA_W];
        sel_op2 = req_op2[i*DATA_W +: DATA_W];
        sel_cin = req_cin[i];
      end
    end
  end

  // Issue stage: capture the accepted operation and advance the rr pointer.
  // Operand registers hold between accepts so the adder inputs stay quiet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= '0;
      iss_valid <= 1'b0;
      iss_id    <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      cin_q     <= 1'b0;
    end else begin
      iss_valid <= accept;
      if (accept) begin
        rr_ptr <= next_ptr;
        iss_id <= grant_idx;
        op1_q  <= sel_op1;
        op2_q  <= sel_op2;
        cin_q  <= sel_cin;
      end
    end
  end

  assign add_load     = iss_valid;
  assign add_input_1  = op1_q;
  assign add_input_2  = op2_q;
  assign add_carry_in = cin_q;

  // Tag pipe: one entry per adder stage, loaded from the issue stage on the
  // same edge the adder samples add_load, so the tail lines up with
  // add_load_out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= {iss_valid, MAX_ID_W'(iss_id)};
      for (int i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tail = tag_q[LATENCY-1];

  // Decode the tail id into the requester that should see the result.
  always_comb begin
    resp_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      resp_onehot[i] = (tail.id == MAX_ID_W'(i));
    end
  end

  // Register the adder result and route it. A load_out with no matching
  // tag is reported as tag_err and never turned into a response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= '0;
      resp_sum   <= '0;
      resp_carry <= 1'b0;
      tag_err    <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (add_load_out) begin
        resp_sum   <= add_sum;
        resp_carry <= add_carry;
        if (tail.valid) begin
          resp_valid <= resp_onehot;
        end
      end
      if (add_load_out != tail.valid) begin
        tag_err <= 1'b1;
      end
    end
  end

  // Count operations between accept and response delivery.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({accept, |resp_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign drain_done = (state == ST_DRAIN) && (inflight == '0);
  assign dbg_state  = state;

`ifdef ADDER_ARB_STATS_EN
  logic [15:0] gcnt [N_REQ];

  // Per-requester accepted-operation counters that stick at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) begin
        gcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (accept && grant[i] && (gcnt[i] != 16'hFFFF)) begin
          gcnt[i] <= gcnt[i] + 16'd1;
        end
      end
    end
  end

  // Flatten the counters onto the packed output bus.
  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_cnt[i*16 +: 16] = gcnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_adder_pipe_arbiter.sv
// tb_adder_pipe_arbiter: self-checking bench for adder_pipe_arbiter.
// Supplies a behavioural pipelined adder, drives directed and random
// requester traffic, and checks every cycle against a transaction-level
// reference model (round-robin grant rule, sum = op1+op2+cin, result due
// 2+LATENCY cycles after accept).
module tb_adder_pipe_arbiter;
  import adder_arb_pkg::*;

  localparam int DATA_W  = 8;
  localparam int N_REQ   = 2;
  localparam int LATENCY = 2;
  localparam int EW      = N_REQ + 1 + DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N_REQ-1:0]        req_valid = '0;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*DATA_W-1:0] req_op1 = '0;
  logic [N_REQ*DATA_W-1:0] req_op2 = '0;
  logic [N_REQ-1:0]        req_cin = '0;
  logic [DATA_W-1:0]       add_input_1, add_input_2;
  logic                    add_carry_in, add_load;
  logic [DATA_W-1:0]       add_sum;
  logic                    add_carry, add_load_out;
  logic [N_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]       resp_sum;
  logic                    resp_carry;
  logic                    drain_req = 1'b0;
  logic                    drain_done, tag_err;
  state_t                  dbg_state;
`ifdef ADDER_ARB_STATS_EN
  logic [N_REQ*16-1:0]     grant_cnt;
`endif
  logic                    force_lo = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  adder_pipe_arbiter #(.DATA_W(DATA_W), .N_REQ(N_REQ), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .reset        (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op1      (req_op1),
    .req_op2      (req_op2),
    .req_cin      (req_cin),
    .add_input_1  (add_input_1),
    .add_input_2  (add_input_2),
    .add_carry_in (add_carry_in),
    .add_load     (add_load),
    .add_sum      (add_sum),
    .add_carry    (add_carry),
    .add_load_out (add_load_out),
    .resp_valid   (resp_valid),
    .resp_sum     (resp_sum),
    .resp_carry   (resp_carry),
    .drain_req    (drain_req),
    .drain_done   (drain_done),
    .tag_err      (tag_err),
`ifdef ADDER_ARB_STATS_EN
    .grant_cnt    (grant_cnt),
`endif
    .dbg_state    (dbg_state)
  );

  // ---------------- external adder model ----------------
  logic [LATENCY-1:0] ad_v;
  logic [DATA_W:0]    ad_r [LATENCY];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ad_v <= '0;
      for (int i = 0; i < LATENCY; i++) ad_r[i] <= '0;
    end else begin
      ad_v[0] <= add_load;
      ad_r[0] <= {1'b0, add_input_1} + {1'b0, add_input_2} + {{DATA_W{1'b0}}, add_carry_in};
      for (int i = 1; i < LATENCY; i++) begin
        ad_v[i] <= ad_v[i-1];
        ad_r[i] <= ad_r[i-1];
      end
    end
  end

  assign add_load_out = ad_v[LATENCY-1] | force_lo;
  assign add_sum      = ad_r[LATENCY-1][DATA_W-1:0];
  assign add_carry    = ad_r[LATENCY-1][DATA_W];

  // ---------------- reference model + scoreboard ----------------
  logic [EW-1:0]     exp_q[$];
  int                due_q[$];
  int                ncyc      = 0;
  int                m_ptr     = 0;
  logic              m_drain   = 1'b0;
  int                m_out     = 0;
  logic              m_iss_v   = 1'b0;
  logic [DATA_W-1:0] m_a       = '0;
  logic [DATA_W-1:0] m_b       = '0;
  logic              m_c       = 1'b0;
  logic              m_tag_err = 1'b0;
  logic [15:0]       m_gcnt [N_REQ];
  logic [N_REQ-1:0]  last_acc  = '0;

  always @(negedge clk) begin : monitor
    int                g;
    logic [N_REQ-1:0]  exp_ready;
    logic [EW-1:0]     e;
    logic              delivered;
    logic [DATA_W:0]   s;
    logic [DATA_W-1:0] a, b;
    logic              c;
    if (rst) begin
      exp_q.delete();
      due_q.delete();
      m_ptr = 0; m_drain = 1'b0; m_out = 0; m_iss_v = 1'b0; m_tag_err = 1'b0;
      last_acc = '0;
      for (int i = 0; i < N_REQ; i++) m_gcnt[i] = '0;
    end else begin
      g = -1;
      if (!m_drain && !drain_req) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % N_REQ]) g = (m_ptr + k) % N_REQ;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      n_checks++;
      if (req_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL mon_req_ready cyc=%0d actual=%b expected=%b", ncyc, req_ready, exp_ready);
      end
      n_checks++;
      if (add_load !== m_iss_v) begin
        n_fail++;
        $display("FAIL mon_add_load cyc=%0d actual=%b expected=%b", ncyc, add_load, m_iss_v);
      end
      if (m_iss_v) begin
        n_checks++;
        if ({add_input_1, add_input_2, add_carry_in} !== {m_a, m_b, m_c}) begin
          n_fail++;
          $display("FAIL mon_operands cyc=%0d actual=%h/%h/%b expected=%h/%h/%b",
                   ncyc, add_input_1, add_input_2, add_carry_in, m_a, m_b, m_c);
        end
      end
      delivered = 1'b0;
      if (due_q.size() > 0 && due_q[0] == ncyc) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        delivered = 1'b1;
        n_checks++;
        if ({resp_valid, resp_carry, resp_sum} !== e) begin
          n_fail++;
          $display("FAIL mon_resp cyc=%0d actual=%b/%b/%h expected=%b/%b/%h", ncyc,
                   resp_valid, resp_carry, resp_sum, e[EW-1 -: N_REQ], e[DATA_W], e[DATA_W-1:0]);
        end
      end else begin
        n_checks++;
        if (resp_valid !== '0) begin
          n_fail++;
          $display("FAIL mon_resp_idle cyc=%0d actual=%b expected=0", ncyc, resp_valid);
        end
      end
      n_checks++;
      if (drain_done !== (m_drain && m_out == 0)) begin
        n_fail++;
        $display("FAIL mon_drain_done cyc=%0d actual=%b expected=%b", ncyc, drain_done, (m_drain && m_out == 0));
      end
      n_checks++;
      if (tag_err !== m_tag_err) begin
        n_fail++;
        $display("FAIL mon_tag_err cyc=%0d actual=%b expected=%b", ncyc, tag_err, m_tag_err);
      end
      n_checks++;
      if (dbg_state !== (m_drain ? ST_DRAIN : ST_RUN)) begin
        n_fail++;
        $display("FAIL mon_state cyc=%0d actual=%0d expected=%0d", ncyc, dbg_state, m_drain);
      end
      // advance the model to the next cycle
      if (g >= 0) begin
        a = req_op1[g*DATA_W +: DATA_W];
        b = req_op2[g*DATA_W +: DATA_W];
        c = req_cin[g];
        s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, c};
        exp_q.push_back({exp_ready, s[DATA_W], s[DATA_W-1:0]});
        due_q.push_back(ncyc + 2 + LATENCY);
        m_iss_v = 1'b1; m_a = a; m_b = b; m_c = c;
        m_ptr = (g + 1) % N_REQ;
        m_out++;
        if (m_gcnt[g] != 16'hFFFF) m_gcnt[g] = m_gcnt[g] + 16'd1;
      end else begin
        m_iss_v = 1'b0;
      end
      if (delivered) m_out--;
      if (force_lo) m_tag_err = 1'b1;
      m_drain  = drain_req;
      last_acc = req_valid & req_ready;
    end
    ncyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int i, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic c);
    req_op1[i*DATA_W +: DATA_W] = a;
    req_op2[i*DATA_W +: DATA_W] = b;
    req_cin[i] = c;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    n_checks++;
    if (resp_valid !== '0 || resp_sum !== '0 || resp_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_resp actual=%b/%h/%b expected=0/0/0", resp_valid, resp_sum, resp_carry);
    end
    n_checks++;
    if (add_load !== 1'b0 || add_input_1 !== '0 || add_input_2 !== '0 || add_carry_in !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_adder_if actual=%b/%h/%h/%b expected=0", add_load, add_input_1, add_input_2, add_carry_in);
    end
    n_checks++;
    if (drain_done !== 1'b0 || tag_err !== 1'b0 || req_ready !== '0) begin
      n_fail++;
      $display("FAIL reset_status actual=%b/%b/%b expected=0/0/0", drain_done, tag_err, req_ready);
    end
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (dbg_state !== ST_RUN || add_load !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release actual=%0d/%b expected=RUN/0", dbg_state, add_load);
    end
  endtask

  task automatic test_single_op();
    step();
    set_op(0, 8'd1, 8'd2, 1'b0);
    req_valid = 2'b01;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL single_ready actual=%b expected=01", req_ready);
    end
    step();
    req_valid = '0;
    @(negedge clk);
    n_checks++;
    if (add_load !== 1'b1 || add_input_1 !== 8'd1 || add_input_2 !== 8'd2 || add_carry_in !== 1'b0) begin
      n_fail++;
      $display("FAIL single_issue actual=%b/%h/%h/%b expected=1/01/02/0", add_load, add_input_1, add_input_2, add_carry_in);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (resp_valid !== 2'b01 || resp_sum !== 8'd3 || resp_carry !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp actual=%b/%h/%b expected=01/03/0", resp_valid, resp_sum, resp_carry);
    end
    repeat (3) step();
  endtask

  task automatic test_carry();
    bit found = 1'b0;
    step();
    set_op(1, 8'hFF, 8'h01, 1'b1);
    req_valid = 2'b10;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_fail++;
      $display("FAIL carry_ready actual=%b expected=10", req_ready);
    end
    step();
    req_valid = '0;
    for (int k = 0; k < 12 && !found; k++) begin
      @(negedge clk);
      if (resp_valid !== '0) begin
        found = 1'b1;
        n_checks++;
        if (resp_valid !== 2'b10 || resp_sum !== 8'h01 || resp_carry !== 1'b1) begin
          n_fail++;
          $display("FAIL carry_resp actual=%b/%h/%b expected=10/01/1", resp_valid, resp_sum, resp_carry);
        end
      end
    end
    if (!found) begin
      n_checks++;
      n_fail++;
      $display("FAIL carry_timeout actual=no_resp expected=resp");
    end
    repeat (3) step();
  endtask

  task automatic test_contention();
    int r = 0;
    step();
    set_op(0, 8'd3, 8'd4, 1'b0);
    set_op(1, 8'd5, 8'd6, 1'b0);
    req_valid = 2'b11;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k < 6) begin
        n_checks++;
        if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
          n_fail++;
          $display("FAIL contention_grant k=%0d actual=%b expected=%b", k, req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      if (resp_valid !== '0) begin
        n_checks++;
        if (resp_valid !== ((r % 2 == 0) ? 2'b01 : 2'b10) || resp_sum !== ((r % 2 == 0) ? 8'd7 : 8'd11)) begin
          n_fail++;
          $display("FAIL contention_resp r=%0d actual=%b/%0d expected=%b/%0d", r, resp_valid, resp_sum,
                   (r % 2 == 0) ? 2'b01 : 2'b10, (r % 2 == 0) ? 7 : 11);
        end
        r++;
      end
      step();
      if (k == 5) req_valid = '0;
    end
    n_checks++;
    if (r != 6) begin
      n_fail++;
      $display("FAIL contention_count actual=%0d expected=6", r);
    end
  endtask

  task automatic test_drain();
    int  r = 0;
    bit  found = 1'b0;
    bit  resumed = 1'b0;
    step();
    set_op(0, DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 1)));
    set_op(1, DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 1)));
    req_valid = 2'b11;
    repeat (3) step();
    drain_req = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== '0) begin
      n_fail++;
      $display("FAIL drain_ready_block actual=%b expected=00", req_ready);
    end
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (resp_valid !== '0) r++;
      if (r == 3) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL drain_resp_timeout actual=%0d expected=3", r);
    end else begin
      @(negedge clk);
      if (drain_done !== 1'b1) begin
        n_fail++;
        $display("FAIL drain_done actual=%b expected=1", drain_done);
      end
    end
    step();
    drain_req = 1'b0;
    for (int k = 0; k < 5 && !resumed; k++) begin
      @(negedge clk);
      if (req_ready !== '0) resumed = 1'b1;
    end
    n_checks++;
    if (!resumed) begin
      n_fail++;
      $display("FAIL drain_resume actual=00 expected=grant");
    end
    step();
    req_valid = '0;
    repeat (8) step();
  endtask

  task automatic test_reset_midflight();
    int r = 0;
    step();
    set_op(0, 8'd10, 8'd20, 1'b0);
    set_op(1, 8'd30, 8'd40, 1'b1);
    req_valid = 2'b11;
    repeat (2) step();
    req_valid = '0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid !== '0) r++;
    end
    n_checks++;
    if (r != 0) begin
      n_fail++;
      $display("FAIL midflight_resp actual=%0d expected=0", r);
    end
    n_checks++;
    if (tag_err !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_tag_err actual=%b expected=0", tag_err);
    end
    step();
    drain_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (drain_done !== 1'b1) begin
      n_fail++;
      $display("FAIL midflight_count_zero actual=%b expected=1", drain_done);
    end
    step();
    drain_req = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_tag_err();
    repeat (6) step();
    force_lo = 1'b1;
    step();
    force_lo = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tag_err !== 1'b1 || resp_valid !== '0) begin
      n_fail++;
      $display("FAIL tag_err_set actual=%b/%b expected=1/00", tag_err, resp_valid);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (tag_err !== 1'b1) begin
      n_fail++;
      $display("FAIL tag_err_sticky actual=%b expected=1", tag_err);
    end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (tag_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tag_err_clear actual=%b expected=0", tag_err);
    end
  endtask

  task automatic test_random();
    logic [N_REQ-1:0] cur_v = '0;
    for (int k = 0; k < 400; k++) begin
      step();
      for (int i = 0; i < N_REQ; i++) begin
        if (!cur_v[i] || last_acc[i]) begin
          cur_v[i] = ($urandom_range(0, 99) < 55);
          set_op(i, DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 1)));
        end
      end
      req_valid = cur_v;
      if (drain_req) drain_req = ($urandom_range(0, 99) < 70);
      else           drain_req = ($urandom_range(0, 99) < 4);
    end
    step();
    req_valid = '0;
    drain_req = 1'b0;
    repeat (12) step();
    drain_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (drain_done !== 1'b1) begin
      n_fail++;
      $display("FAIL random_final_drain actual=%b expected=1", drain_done);
    end
    step();
    drain_req = 1'b0;
    repeat (2) step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_op();
    test_carry();
    test_contention();
    test_drain();
    test_reset_midflight();
    test_tag_err();
    test_random();
`ifdef ADDER_ARB_STATS_EN
    @(negedge clk);
    for (int i = 0; i < N_REQ; i++) begin
      n_checks++;
      if (grant_cnt[i*16 +: 16] !== m_gcnt[i]) begin
        n_fail++;
        $display("FAIL grant_cnt[%0d] actual=%0d expected=%0d", i, grant_cnt[i*16 +: 16], m_gcnt[i]);
      end
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
